// File: rtl/shift_rows_if.sv
// Transfer bundle for the ShiftRows stage: input state plus direction in,
// registered permuted state out.
interface shift_rows_if;
   logic [127:0] shftIn;
   logic         inv;
   logic         in_valid;
   logic [127:0] shftOut;
   logic         out_valid;

   modport master (output shftIn, inv, in_valid, input shftOut, out_valid);
   modport slave  (input shftIn, inv, in_valid, output shftOut, out_valid);
endinterface

// File: rtl/shift_rows.sv
// AES ShiftRows / InvShiftRows with a single registered output stage.
// The state is split into four row lanes; each lane is a fixed byte
// rotation whose direction is picked per transfer by inv.

// One state row: rotate left by ROW bytes (forward) or right by ROW (inverse).
// Element c of rowIn/rowOut is column c of that row.
module shift_rows_row #(
   parameter int ROW   = 0,
   parameter int VEC_W = 8
) (
   input  logic                  inv,
   input  logic [3:0][VEC_W-1:0] rowIn,
   output logic [3:0][VEC_W-1:0] rowOut
);
   for (genvar c = 0; c < 4; c++) begin : g_col
      localparam int FWD = (c + ROW) % 4;
      localparam int INV = (c - ROW + 4) % 4;
      assign rowOut[c] = inv ? rowIn[INV] : rowIn[FWD];
   end
endmodule

module shift_rows (
   input  logic         clk,
   input  logic         rst_n,
   shift_rows_if.slave  bus
);
   localparam int NUM_LANES = 4;   // rows
   localparam int VEC_W     = 8;   // byte
   localparam int STAGES    = 1;

   // [row][col] views of the state; byte k = r + 4c sits at bits 127-8k.
   logic [NUM_LANES-1:0][3:0][VEC_W-1:0] rowsIn;
   logic [NUM_LANES-1:0][3:0][VEC_W-1:0] rowsOut;
   logic [127:0]                         permuted;
   logic [127:0]                         shftOutQ;
   logic [STAGES:1]                      vldReg;
   logic [STAGES:0]                      vld_pipe;

   for (genvar r = 0; r < NUM_LANES; r++) begin : g_row
      for (genvar c = 0; c < 4; c++) begin : g_byte
         assign rowsIn[r][c]                       = bus.shftIn[127-8*(r+4*c) -: 8];
         assign permuted[127-8*(r+4*c) -: 8]       = rowsOut[r][c];
      end
      shift_rows_row #(.ROW(r), .VEC_W(VEC_W)) u_row (
         .inv    (bus.inv),
         .rowIn  (rowsIn[r]),
         .rowOut (rowsOut[r])
      );
   end

   assign vld_pipe = {vldReg, bus.in_valid};

   // Output register: load only on a valid transfer so idle-cycle X on
   // shftIn never reaches shftOut; valid flag follows in_valid by one cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shftOutQ <= '0;
         vldReg   <= '0;
      end else begin
         vldReg <= vld_pipe[STAGES-1:0];
         if (vld_pipe[0]) shftOutQ <= permuted;
      end
   end

   assign bus.shftOut   = shftOutQ;
   assign bus.out_valid = vld_pipe[STAGES];
endmodule

// File: tb/tb_shift_rows.sv
// Directed and random checks of shift_rows against a byte-array model.
module tb_shift_rows;
   logic clk = 1'b0;
   logic rst_n;
   int   nAssert = 0;
   int   nFail   = 0;

   shift_rows_if bus ();

   shift_rows dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;

   // Reference: s[r][c] = byte r+4c, out[r][c] = in[r][(c +/- r) mod 4].
   function automatic logic [127:0] model(input logic [127:0] x, input logic iv);
      logic [7:0]   b [16];
      logic [127:0] y;
      int           src;
      for (int k = 0; k < 16; k++) b[k] = x[127-8*k -: 8];
      y = '0;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) begin
            src = iv ? (c - r + 4) % 4 : (c + r) % 4;
            y[127-8*(r+4*c) -: 8] = b[r + 4*src];
         end
      return y;
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      nAssert++;
      assert (obs === exp)
      else begin
         nFail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Apply one input cycle at the falling edge, then sample #1 after the
   // following rising edge.
   task automatic step(input logic [127:0] d, input logic iv, input logic v);
      @(negedge clk);
      bus.shftIn   = d;
      bus.inv      = iv;
      bus.in_valid = v;
      @(posedge clk);
      #1;
   endtask

   logic [127:0] d, f, lastOut;
   logic [127:0] vec [4];

   initial begin
      rst_n        = 1'b0;
      bus.shftIn   = '0;
      bus.inv      = 1'b0;
      bus.in_valid = 1'b0;
      #1;
      chk("reset_out",   bus.shftOut, 128'h0);
      chk("reset_valid", {127'h0, bus.out_valid}, 128'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // Forward FIPS-197 vector, constant and model.
      step(128'h63cab7040953d051cd60e0e7ba70e18c, 1'b0, 1'b1);
      chk("fwd_fips",       bus.shftOut, 128'h6353e08c0960e104cd70b751bacad0e7);
      chk("fwd_fips_model", bus.shftOut, model(128'h63cab7040953d051cd60e0e7ba70e18c, 1'b0));
      chk("fwd_valid",      {127'h0, bus.out_valid}, 128'h1);

      // Back-to-back forward transfers.
      vec[0] = 128'ha761ca9b97be8b45d8ad1a611fc97369;
      vec[1] = 128'h3b59cb73fcd90ee05774222dc067fb68;
      vec[2] = 128'h2dfb02343f6d12dd09337ec75b36e3f0;
      vec[3] = 128'h36400926f9336d2d9fb59d23c42c3950;
      step(vec[0], 1'b0, 1'b1); chk("b2b0", bus.shftOut, 128'ha7be1a6997ad739bd8c9ca451f618b61);
      step(vec[1], 1'b0, 1'b1); chk("b2b1", bus.shftOut, 128'h3bd92268fc74fb735767cbe0c0590e2d);
      step(vec[2], 1'b0, 1'b1); chk("b2b2", bus.shftOut, 128'h2d6d7ef03f33e334093602dd5bfb12c7);
      step(vec[3], 1'b0, 1'b1); chk("b2b3", bus.shftOut, 128'h36339d50f9b539269f2c092dc4406d23);
      chk("b2b_valid", {127'h0, bus.out_valid}, 128'h1);

      // Inverse vectors.
      step(128'h6353e08c0960e104cd70b751bacad0e7, 1'b1, 1'b1);
      chk("inv0", bus.shftOut, 128'h63cab7040953d051cd60e0e7ba70e18c);
      step(128'h36339d50f9b539269f2c092dc4406d23, 1'b1, 1'b1);
      chk("inv1", bus.shftOut, 128'h36400926f9336d2d9fb59d23c42c3950);

      // Alternating direction on the same input.
      for (int i = 0; i < 4; i++) begin
         step(128'h000102030405060708090a0b0c0d0e0f, i[0], 1'b1);
         chk(i[0] ? "mix_inv" : "mix_fwd", bus.shftOut,
             i[0] ? 128'h000d0a0704010e0b0805020f0c090603
                  : 128'h00050a0f04090e03080d02070c01060b);
      end
      lastOut = 128'h000d0a0704010e0b0805020f0c090603;

      // Valid gap with X on the data lines: output holds, valid drops.
      for (int i = 0; i < 3; i++) begin
         step('x, 1'bx, 1'b0);
         chk("gap_valid", {127'h0, bus.out_valid}, 128'h0);
         chk("gap_hold",  bus.shftOut, lastOut);
      end

      // Mid-stream asynchronous reset between edges.
      @(negedge clk);
      bus.shftIn   = vec[1];
      bus.inv      = 1'b0;
      bus.in_valid = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_async_out",   bus.shftOut, 128'h0);
      chk("rst_async_valid", {127'h0, bus.out_valid}, 128'h0);
      @(posedge clk);
      #1;
      chk("rst_held_out", bus.shftOut, 128'h0);
      @(negedge clk);
      rst_n = 1'b1;
      step(vec[2], 1'b0, 1'b1);
      chk("post_rst",       bus.shftOut, 128'h2d6d7ef03f33e334093602dd5bfb12c7);
      chk("post_rst_valid", {127'h0, bus.out_valid}, 128'h1);

      // Random round trips: forward against model, inverse recovers input.
      for (int i = 0; i < 1000; i++) begin
         d = {$urandom, $urandom, $urandom, $urandom};
         step(d, 1'b0, 1'b1);
         f = bus.shftOut;
         chk("rnd_fwd", f, model(d, 1'b0));
         step(f, 1'b1, 1'b1);
         chk("rnd_roundtrip", bus.shftOut, d);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
      $finish;
   end
endmodule

// File: doc/shift_rows.md
Name: shift_rows

Overview:
- AES ShiftRows / InvShiftRows byte permutation on a 128-bit state, with a registered output stage.
- Sits in the Rijndael round datapath between SubBytes and MixColumns (encrypt), or after InvSubBytes / round-key stages (decrypt), selected per transfer by inv.
- One clock; reset is asynchronous and active-low.

Parameters:
- None. State width is fixed at 128 bits: 4x4 bytes, 8 bits per byte.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- shftIn  input  128  input state
- inv  input  1  0 = ShiftRows (encrypt), 1 = InvShiftRows (decrypt)
- in_valid  input  1  shftIn/inv valid this cycle
- shftOut  output  128  permuted state (registered)
- out_valid  output  1  shftOut holds a new result

Behaviour:
- Byte mapping (FIPS-197):
  - Byte k = shftIn[127-8k -: 8], k = 0..15.
  - State element s[r][c] = byte r+4c, so column c is bits [127-32c -: 32] and row 0 is the MSB of each column.
- inv=0, forward: out[r][c] = in[r][(c+r) mod 4]. Row 0 unchanged; rows 1, 2, 3 rotate left by 1, 2, 3 bytes.
- inv=1, inverse: out[r][c] = in[r][(c-r) mod 4]. Rows rotate right by r bytes.
- Pure byte permutation, no arithmetic. Inverse(forward(x)) = x for every x.
- Latency: exactly 1 clock.
  - On a rising edge with in_valid=1: shftOut <= permute(shftIn, inv), out_valid <= 1.
  - On a rising edge with in_valid=0: out_valid <= 0, shftOut holds its last value.
- Throughput: one state per cycle, back-to-back, no stalls. No ready/backpressure.
- inv is sampled in the same cycle as shftIn; each transfer may use a different inv.
- Reset:
  - rst_n low immediately forces shftOut = 128'h0 and out_valid = 0, independent of clk.
  - While rst_n is low, inputs are ignored.
  - First capture is on the first rising edge after rst_n deasserts with in_valid=1.
  - Reset mid-stream discards the in-flight result.
- X on shftIn while in_valid=0 must not propagate to shftOut.
- No internal state besides the output register and the valid flag.

Test Plan:
- Forward, inv=0, in_valid=1:
  - 63cab7040953d051cd60e0e7ba70e18c -> 6353e08c0960e104cd70b751bacad0e7, one cycle later, out_valid=1.
- Forward, back-to-back, one input per cycle:
  - a761ca9b97be8b45d8ad1a611fc97369 -> a7be1a6997ad739bd8c9ca451f618b61
  - 3b59cb73fcd90ee05774222dc067fb68 -> 3bd92268fc74fb735767cbe0c0590e2d
  - 2dfb02343f6d12dd09337ec75b36e3f0 -> 2d6d7ef03f33e334093602dd5bfb12c7
  - 36400926f9336d2d9fb59d23c42c3950 -> 36339d50f9b539269f2c092dc4406d23
  - Each result appears on consecutive cycles.
- Inverse, inv=1:
  - 6353e08c0960e104cd70b751bacad0e7 -> 63cab7040953d051cd60e0e7ba70e18c
  - 36339d50f9b539269f2c092dc4406d23 -> 36400926f9336d2d9fb59d23c42c3950
- Mixed inv per cycle, alternating 0/1 on the same input 000102030405060708090a0b0c0d0e0f:
  - inv=0 -> 00050a0f04090e03080d02070c01060b
  - inv=1 -> 000d0a0704010e0b0805020f0c090603
- Valid gap: in_valid=0 for 3 cycles -> out_valid=0, shftOut holds the last result.
- Reset:
  - Assert rst_n=0 between clock edges mid-stream -> shftOut=0 and out_valid=0 immediately.
  - After release, the first valid input produces the correct result one cycle later.
- Random: 1000 random states through forward then inverse -> identity recovered.
